// File: rtl/csr_pkg.sv
// Shared CSR definitions: addresses, field positions, writable masks and exception codes.
package csr_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    localparam int CRMD_IE      = 2;
    localparam int ESTAT_IS_TI  = 11;
    localparam int TCFG_EN      = 0;
    localparam int TCFG_PERIOD  = 1;
    localparam int TICLR_CLR    = 0;

    localparam logic [4:0]  CRMD_RESET  = 5'b01000;
    localparam logic [12:0] ECFG_WMASK  = 13'h1BFF;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

endpackage

// File: rtl/csr_timer.sv
// Constant-frequency timer (TCFG/TVAL), its expiry pulse, and the free-running 64-bit counter.
module csr_timer
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        tcfg_wr,
    input  logic [31:0] tcfg_new,
    output logic [31:0] tcfg,
    output logic [31:0] tval,
    output logic        ti_set,
    output logic [63:0] rdcntv
);

    logic [31:0] tcfg_q, tcfg_d;
    logic [31:0] tval_q, tval_d;
    logic [63:0] cnt_q, cnt_d;

    // A write to TCFG takes precedence over the running countdown in that cycle.
    always_comb begin
        tcfg_d = tcfg_q;
        tval_d = tval_q;
        ti_set = 1'b0;
        cnt_d  = cnt_q + 64'd1;
        if (tcfg_wr) begin
            tcfg_d = tcfg_new;
            if (tcfg_new[TCFG_EN]) begin
                tval_d = {tcfg_new[31:2], 2'b00};
            end
        end else if (tcfg_q[TCFG_EN]) begin
            if (tval_q != 32'd0) begin
                tval_d = tval_q - 32'd1;
                ti_set = (tval_q == 32'd1);
            end else if (tcfg_q[TCFG_PERIOD]) begin
                tval_d = {tcfg_q[31:2], 2'b00};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tcfg_q <= 32'd0;
            tval_q <= 32'd0;
            cnt_q  <= 64'd0;
        end else begin
            tcfg_q <= tcfg_d;
            tval_q <= tval_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tcfg   = tcfg_q;
    assign tval   = tval_q;
    assign rdcntv = cnt_q;

endmodule

// File: rtl/csr_regfile.sv
// CSR register file: architectural CSRs, exception entry/return state and interrupt request.
module csr_regfile
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [13:0] rd_addr,
    output logic [31:0] rd_data,
    input  logic [13:0] wb_csr_waddr,
    input  logic [31:0] wb_csr_we,
    input  logic [31:0] wb_csr_wdata,
    input  logic [6:0]  wb_ecode_in,
    input  logic        wb_ecode_we,
    input  logic [31:0] wb_badv_in,
    input  logic        wb_badv_we,
    input  logic [31:0] wb_era_in,
    input  logic        wb_era_we,
    input  logic        wb_store_state,
    input  logic        wb_restore_state,
    input  logic        wb_eentry_en,
    input  logic        wb_era_en,
    input  logic [7:0]  hw_int_in,
    output logic        interrupt,
    output logic [31:0] redirect_pc,
    output logic [1:0]  plv,
    output logic        ie,
    output logic [63:0] rdcntv,
    output logic [31:0] rdcntid
);

    logic [4:0]  crmd_q, crmd_d;
    logic [2:0]  prmd_q, prmd_d;
    logic [12:0] ecfg_q, ecfg_d;
    logic [1:0]  is_sw_q, is_sw_d;
    logic [7:0]  is_hw_q, is_hw_d;
    logic        is_ti_q, is_ti_d;
    logic [5:0]  ecode_q, ecode_d;
    logic        esub_q, esub_d;
    logic [31:0] era_q, era_d;
    logic [31:0] badv_q, badv_d;
    logic [25:0] eentry_q, eentry_d;
    logic [31:0] save_q [4];
    logic [31:0] save_d [4];
    logic [31:0] tid_q, tid_d;

    logic [31:0] tcfg, tval, wr_new;
    logic        ti_set, sw_wr, ticlr_hit;
    logic [12:0] is_all;

    function automatic logic [31:0] csr_view(input logic [13:0] a);
        case (a)
            CSR_CRMD:   csr_view = {27'b0, crmd_q};
            CSR_PRMD:   csr_view = {29'b0, prmd_q};
            CSR_ECFG:   csr_view = {19'b0, ecfg_q};
            CSR_ESTAT:  csr_view = {9'b0, esub_q, ecode_q, 4'b0, is_ti_q, 1'b0, is_hw_q, is_sw_q};
            CSR_ERA:    csr_view = era_q;
            CSR_BADV:   csr_view = badv_q;
            CSR_EENTRY: csr_view = {eentry_q, 6'b0};
            CSR_SAVE0:  csr_view = save_q[0];
            CSR_SAVE1:  csr_view = save_q[1];
            CSR_SAVE2:  csr_view = save_q[2];
            CSR_SAVE3:  csr_view = save_q[3];
            CSR_TID:    csr_view = tid_q;
            CSR_TCFG:   csr_view = tcfg;
            CSR_TVAL:   csr_view = tval;
            default:    csr_view = 32'd0;
        endcase
    endfunction

    assign sw_wr     = |wb_csr_we;
    assign wr_new    = (csr_view(wb_csr_waddr) & ~wb_csr_we) | (wb_csr_wdata & wb_csr_we);
    assign ticlr_hit = (wb_csr_waddr == CSR_TICLR) && wb_csr_we[TICLR_CLR] && wb_csr_wdata[TICLR_CLR];

    csr_timer u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .tcfg_wr  (sw_wr && (wb_csr_waddr == CSR_TCFG)),
        .tcfg_new (wr_new),
        .tcfg     (tcfg),
        .tval     (tval),
        .ti_set   (ti_set),
        .rdcntv   (rdcntv)
    );

    // Software write first, then hardware updates overwrite the same fields.
    always_comb begin
        crmd_d   = crmd_q;
        prmd_d   = prmd_q;
        ecfg_d   = ecfg_q;
        is_sw_d  = is_sw_q;
        is_hw_d  = hw_int_in;
        is_ti_d  = is_ti_q;
        ecode_d  = ecode_q;
        esub_d   = esub_q;
        era_d    = era_q;
        badv_d   = badv_q;
        eentry_d = eentry_q;
        save_d   = save_q;
        tid_d    = tid_q;
        if (sw_wr) begin
            case (wb_csr_waddr)
                CSR_CRMD:   crmd_d    = wr_new[4:0];
                CSR_PRMD:   prmd_d    = wr_new[2:0];
                CSR_ECFG:   ecfg_d    = wr_new[12:0] & ECFG_WMASK;
                CSR_ESTAT:  is_sw_d   = wr_new[1:0];
                CSR_ERA:    era_d     = wr_new;
                CSR_BADV:   badv_d    = wr_new;
                CSR_EENTRY: eentry_d  = wr_new[31:6];
                CSR_SAVE0:  save_d[0] = wr_new;
                CSR_SAVE1:  save_d[1] = wr_new;
                CSR_SAVE2:  save_d[2] = wr_new;
                CSR_SAVE3:  save_d[3] = wr_new;
                CSR_TID:    tid_d     = wr_new;
                default:    ;
            endcase
        end
        if (wb_store_state) begin
            prmd_d      = crmd_q[2:0];
            crmd_d[2:0] = 3'b000;
        end else if (wb_restore_state) begin
            crmd_d[2:0] = prmd_q;
        end
        if (wb_ecode_we) begin
            {esub_d, ecode_d} = wb_ecode_in;
        end
        if (wb_badv_we) begin
            badv_d = wb_badv_in;
        end
        if (wb_era_we) begin
            era_d = wb_era_in;
        end
        if (ti_set) begin
            is_ti_d = 1'b1;
        end else if (ticlr_hit) begin
            is_ti_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            crmd_q   <= CRMD_RESET;
            prmd_q   <= 3'd0;
            ecfg_q   <= 13'd0;
            is_sw_q  <= 2'd0;
            is_hw_q  <= 8'd0;
            is_ti_q  <= 1'b0;
            ecode_q  <= 6'd0;
            esub_q   <= 1'b0;
            era_q    <= 32'd0;
            badv_q   <= 32'd0;
            eentry_q <= 26'd0;
            save_q   <= '{default: 32'd0};
            tid_q    <= 32'd0;
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            ecfg_q   <= ecfg_d;
            is_sw_q  <= is_sw_d;
            is_hw_q  <= is_hw_d;
            is_ti_q  <= is_ti_d;
            ecode_q  <= ecode_d;
            esub_q   <= esub_d;
            era_q    <= era_d;
            badv_q   <= badv_d;
            eentry_q <= eentry_d;
            save_q   <= save_d;
            tid_q    <= tid_d;
        end
    end

    assign is_all      = {1'b0, is_ti_q, 1'b0, is_hw_q, is_sw_q};
    assign interrupt   = crmd_q[CRMD_IE] & |(is_all & ecfg_q);
    assign rd_data     = csr_view(rd_addr);
    assign redirect_pc = wb_eentry_en ? {eentry_q, 6'b0} : (wb_era_en ? era_q : 32'd0);
    assign plv         = crmd_q[1:0];
    assign ie          = crmd_q[CRMD_IE];
    assign rdcntid     = tid_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Randomized and directed bench for csr_regfile against an array-based CSR reference model.
module tb_csr_regfile;

  localparam int A_CRMD = 'h0, A_PRMD = 'h1, A_ECFG = 'h4, A_ESTAT = 'h5, A_ERA = 'h6;
  localparam int A_BADV = 'h7, A_EENTRY = 'hC, A_SAVE0 = 'h30, A_SAVE3 = 'h33;
  localparam int A_TID = 'h40, A_TCFG = 'h41, A_TVAL = 'h42, A_TICLR = 'h44;

  logic        clk;
  logic        rstn;
  logic [13:0] rd_addr;
  logic [31:0] rd_data;
  logic [13:0] wb_csr_waddr;
  logic [31:0] wb_csr_we;
  logic [31:0] wb_csr_wdata;
  logic [6:0]  wb_ecode_in;
  logic        wb_ecode_we;
  logic [31:0] wb_badv_in;
  logic        wb_badv_we;
  logic [31:0] wb_era_in;
  logic        wb_era_we;
  logic        wb_store_state;
  logic        wb_restore_state;
  logic        wb_eentry_en;
  logic        wb_era_en;
  logic [7:0]  hw_int_in;
  logic        interrupt;
  logic [31:0] redirect_pc;
  logic [1:0]  plv;
  logic        ie;
  logic [63:0] rdcntv;
  logic [31:0] rdcntid;

  csr_regfile dut (
    .clk              (clk),
    .rstn             (rstn),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .wb_csr_waddr     (wb_csr_waddr),
    .wb_csr_we        (wb_csr_we),
    .wb_csr_wdata     (wb_csr_wdata),
    .wb_ecode_in      (wb_ecode_in),
    .wb_ecode_we      (wb_ecode_we),
    .wb_badv_in       (wb_badv_in),
    .wb_badv_we       (wb_badv_we),
    .wb_era_in        (wb_era_in),
    .wb_era_we        (wb_era_we),
    .wb_store_state   (wb_store_state),
    .wb_restore_state (wb_restore_state),
    .wb_eentry_en     (wb_eentry_en),
    .wb_era_en        (wb_era_en),
    .hw_int_in        (hw_int_in),
    .interrupt        (interrupt),
    .redirect_pc      (redirect_pc),
    .plv              (plv),
    .ie               (ie),
    .rdcntv           (rdcntv),
    .rdcntid          (rdcntid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_en   = 1'b0;
  logic [31:0] exp_q[$];

  logic [31:0] m_reg [0:127];
  logic [31:0] m_nxt [0:127];
  logic [63:0] m_cnt, m_cnt_nxt;

  logic [13:0] addr_tab [0:17] = '{14'h0, 14'h1, 14'h4, 14'h5, 14'h6, 14'h7, 14'hC, 14'h30, 14'h31,
                                   14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h2, 14'h45, 14'h1005};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] wmask(input int a);
    case (a)
      A_CRMD:   return 32'h0000_001F;
      A_PRMD:   return 32'h0000_0007;
      A_ECFG:   return 32'h0000_1BFF;
      A_ESTAT:  return 32'h0000_0003;
      A_EENTRY: return 32'hFFFF_FFC0;
      A_ERA, A_BADV, A_TID, A_TCFG, 'h30, 'h31, 'h32, A_SAVE3: return 32'hFFFF_FFFF;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic bit readable(input int a);
    return (wmask(a) != 0) || (a == A_TVAL);
  endfunction

  function automatic logic [31:0] m_read(input logic [13:0] a);
    if (readable(int'(a))) return m_reg[a[6:0]];
    return 32'h0;
  endfunction

  task automatic model_reset_now();
    for (int i = 0; i < 128; i++) m_reg[i] = 32'h0;
    m_reg[A_CRMD] = 32'h8;
    m_cnt = 64'h0;
  endtask

  task automatic model_step();
    logic [31:0] m, t;
    logic [6:0]  ix;
    int          a;
    bit          tset;
    m_nxt     = m_reg;
    m_cnt_nxt = m_cnt + 64'd1;
    if (!rstn) begin
      for (int i = 0; i < 128; i++) m_nxt[i] = 32'h0;
      m_nxt[A_CRMD] = 32'h8;
      m_cnt_nxt = 64'h0;
      return;
    end
    a  = int'(wb_csr_waddr);
    ix = wb_csr_waddr[6:0];
    m  = wmask(a);
    if (wb_csr_we != 0 && m != 0)
      m_nxt[ix] = (m_reg[ix] & ~(wb_csr_we & m)) | (wb_csr_wdata & wb_csr_we & m);
    if (wb_store_state) begin
      m_nxt[A_PRMD][2:0] = m_reg[A_CRMD][2:0];
      m_nxt[A_CRMD][2:0] = 3'b000;
    end else if (wb_restore_state) begin
      m_nxt[A_CRMD][2:0] = m_reg[A_PRMD][2:0];
    end
    if (wb_ecode_we) m_nxt[A_ESTAT][22:16] = wb_ecode_in;
    if (wb_badv_we)  m_nxt[A_BADV] = wb_badv_in;
    if (wb_era_we)   m_nxt[A_ERA] = wb_era_in;
    m_nxt[A_ESTAT][9:2] = hw_int_in;
    tset = 1'b0;
    t = m_reg[A_TCFG];
    if (wb_csr_we != 0 && a == A_TCFG) begin
      if (m_nxt[A_TCFG][0]) m_nxt[A_TVAL] = {m_nxt[A_TCFG][31:2], 2'b00};
    end else if (t[0]) begin
      if (m_reg[A_TVAL] != 0) begin
        m_nxt[A_TVAL] = m_reg[A_TVAL] - 32'd1;
        tset = (m_reg[A_TVAL] == 32'd1);
      end else if (t[1]) begin
        m_nxt[A_TVAL] = {t[31:2], 2'b00};
      end
    end
    if (tset) m_nxt[A_ESTAT][11] = 1'b1;
    else if (a == A_TICLR && wb_csr_we[0] && wb_csr_wdata[0]) m_nxt[A_ESTAT][11] = 1'b0;
  endtask

  task automatic check_all();
    logic [31:0] crmd, pc;
    logic        irq;
    crmd = m_reg[A_CRMD];
    irq  = crmd[2] & |(m_reg[A_ESTAT][12:0] & m_reg[A_ECFG][12:0]);
    pc   = wb_eentry_en ? m_reg[A_EENTRY] : (wb_era_en ? m_reg[A_ERA] : 32'h0);
    exp_q.push_back(m_read(rd_addr));
    check_eq("rd_data", rd_data, exp_q.pop_front());
    check_eq("interrupt", interrupt, irq);
    check_eq("redirect_pc", redirect_pc, pc);
    check_eq("plv", plv, crmd[1:0]);
    check_eq("ie", ie, crmd[2]);
    check_eq("rdcntv", rdcntv, m_cnt);
    check_eq("rdcntid", rdcntid, m_reg[A_TID]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    #1;
    if (chk_en) check_all();
    model_step();
    @(posedge clk);
    m_reg = m_nxt;
    m_cnt = m_cnt_nxt;
    #1;
  endtask

  task automatic peek(input int a, output logic [31:0] v);
    rd_addr = 14'(a);
    #1;
    v = rd_data;
  endtask

  task automatic csr_wr(input int a, input logic [31:0] we, input logic [31:0] d);
    wb_csr_waddr = 14'(a);
    wb_csr_we    = we;
    wb_csr_wdata = d;
    tick();
    wb_csr_we    = 32'h0;
    wb_csr_wdata = 32'h0;
  endtask

  task automatic idle_inputs();
    wb_csr_waddr = 14'h0; wb_csr_we = 32'h0; wb_csr_wdata = 32'h0;
    wb_ecode_in = 7'h0; wb_ecode_we = 1'b0;
    wb_badv_in = 32'h0; wb_badv_we = 1'b0;
    wb_era_in = 32'h0; wb_era_we = 1'b0;
    wb_store_state = 1'b0; wb_restore_state = 1'b0;
    wb_eentry_en = 1'b0; wb_era_en = 1'b0;
    hw_int_in = 8'h0; rd_addr = 14'h0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset_now();
    chk_en = 1'b1;
    repeat (2) tick();
    peek(A_CRMD, v);
    check_eq("reset_crmd", v, 32'h8);
    check_eq("reset_irq", interrupt, 1'b0);
    check_eq("reset_pc", redirect_pc, 32'h0);
    check_eq("reset_cnt", rdcntv, 64'h0);
    rstn = 1'b1;
    tick();
    check_eq("cnt_first", rdcntv, 64'h1);

    csr_wr(A_CRMD, 32'h7, 32'h5);
    check_eq("crmd_plv", plv, 2'd1);
    check_eq("crmd_ie", ie, 1'b1);
    peek(A_CRMD, v);
    check_eq("crmd_da", v, 32'hD);

    csr_wr(A_CRMD, 32'h3, 32'h3);
    wb_store_state = 1'b1; tick(); wb_store_state = 1'b0;
    peek(A_PRMD, v);
    check_eq("store_prmd", v, 32'h7);
    check_eq("store_plv", plv, 2'd0);
    check_eq("store_ie", ie, 1'b0);
    wb_restore_state = 1'b1; tick(); wb_restore_state = 1'b0;
    check_eq("restore_plv", plv, 2'd3);
    check_eq("restore_ie", ie, 1'b1);

    wb_ecode_in = 7'h08; wb_ecode_we = 1'b1;
    csr_wr(A_ESTAT, 32'hFFFF_FFFF, 32'h007F_0003);
    wb_ecode_we = 1'b0; wb_ecode_in = 7'h0;
    peek(A_ESTAT, v);
    check_eq("ecode_prio", v, 32'h0008_0003);
    csr_wr(A_ESTAT, 32'h3, 32'h0);

    csr_wr(A_TCFG, 32'hFFFF_FFFF, 32'h11);
    peek(A_TVAL, v);
    check_eq("oneshot_load", v, 32'h10);
    repeat (15) tick();
    peek(A_TVAL, v);
    check_eq("oneshot_tval1", v, 32'h1);
    peek(A_ESTAT, v);
    check_eq("oneshot_is_early", v[11], 1'b0);
    tick();
    peek(A_ESTAT, v);
    check_eq("oneshot_is_set", v[11], 1'b1);
    repeat (3) tick();
    peek(A_TVAL, v);
    check_eq("oneshot_hold", v, 32'h0);
    csr_wr(A_TICLR, 32'h1, 32'h1);
    peek(A_ESTAT, v);
    check_eq("ticlr_clear", v[11], 1'b0);
    csr_wr(A_TCFG, 32'hFFFF_FFFF, 32'h0);

    csr_wr(A_ECFG, 32'hFFFF_FFFF, 32'h800);
    csr_wr(A_TCFG, 32'hFFFF_FFFF, 32'h13);
    check_eq("periodic_irq_idle", interrupt, 1'b0);
    repeat (15) tick();
    check_eq("periodic_irq_early", interrupt, 1'b0);
    tick();
    check_eq("periodic_irq", interrupt, 1'b1);
    tick();
    peek(A_TVAL, v);
    check_eq("periodic_reload", v, 32'h10);
    csr_wr(A_TICLR, 32'h1, 32'h1);
    check_eq("periodic_ack", interrupt, 1'b0);

    repeat (5) tick();
    peek(A_TVAL, v);
    check_eq("midcount_tval", v, 32'hA);
    rstn = 1'b0; tick();
    peek(A_TVAL, v);
    check_eq("rst_tval", v, 32'h0);
    peek(A_ESTAT, v);
    check_eq("rst_estat", v, 32'h0);
    peek(A_CRMD, v);
    check_eq("rst_crmd", v, 32'h8);
    check_eq("rst_cnt", rdcntv, 64'h0);
    rstn = 1'b1; tick();
    check_eq("rst_cnt_restart", rdcntv, 64'h1);
    repeat (20) tick();
    peek(A_ESTAT, v);
    check_eq("rst_no_pending", v[11], 1'b0);

    for (int i = 0; i < 600; i++) begin
      wb_csr_waddr = addr_tab[$urandom_range(0, 17)];
      case ($urandom_range(0, 3))
        0:       wb_csr_we = 32'h0;
        1:       wb_csr_we = 32'hFFFF_FFFF;
        default: wb_csr_we = $urandom;
      endcase
      wb_csr_wdata = $urandom;
      if (wb_csr_waddr == 14'h41) wb_csr_wdata = ($urandom_range(0, 12) << 2) | $urandom_range(0, 3);
      wb_store_state   = ($urandom_range(0, 15) == 0);
      wb_restore_state = !wb_store_state && ($urandom_range(0, 15) == 0);
      wb_ecode_we  = ($urandom_range(0, 3) == 0);
      wb_ecode_in  = 7'($urandom);
      wb_badv_we   = ($urandom_range(0, 3) == 0);
      wb_badv_in   = $urandom;
      wb_era_we    = ($urandom_range(0, 3) == 0);
      wb_era_in    = $urandom;
      wb_eentry_en = 1'($urandom);
      wb_era_en    = 1'($urandom);
      hw_int_in    = 8'($urandom);
      rd_addr      = addr_tab[$urandom_range(0, 17)];
      rstn         = ($urandom_range(0, 199) != 0);
      tick();
    end
    idle_inputs();
    rstn = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
